tile_controller: RTL and testbench

- Computes one Winograd F(4x4,3x3) tile: a 3x3 kernel and a 6x6 input tile produce a 4x4 output tile.
- The output equals the direct "valid" 2-D correlation of the tile with the kernel.
- Multi-cycle, start/done handshake.
- Used as the per-tile compute engine under a higher-level convolution/tiling controller.

---
 rtl/winograd_pkg.sv | 62 ++++++
 rtl/winograd_output_xform.sv | 55 +++++
 rtl/tile_controller.sv | 192 +++++++++++++++++++
 tb/tb_tile_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared constants and types for the Winograd F(4x4,3x3) tile engine.
// Holds the transform matrices (B^T, 24*G, A^T), tile geometry, the
// output scale factor, the FSM state encoding and default-width element
// array types.
package winograd_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ACC_W  = 64;

  localparam int TILE_IN  = 6;
  localparam int TILE_OUT = 4;
  localparam int K        = 3;
  localparam int SCALE    = 576;  // (24)^2 from using 24*G on both sides

  localparam int BT [TILE_IN][TILE_IN] = '{
    '{4,  0, -5,  0, 1, 0},
    '{0, -4, -4,  1, 1, 0},
    '{0,  4, -4, -1, 1, 0},
    '{0, -2, -1,  2, 1, 0},
    '{0,  2, -1, -2, 1, 0},
    '{0,  4,  0, -5, 0, 1}
  };

  localparam int GS [TILE_IN][K] = '{
    '{ 6,  0,  0},
    '{-4, -4, -4},
    '{-4,  4, -4},
    '{ 1,  2,  4},
    '{ 1, -2,  4},
    '{ 0,  0, 24}
  };

  localparam int AT [TILE_OUT][TILE_IN] = '{
    '{1, 1,  1, 1,  1, 0},
    '{0, 1, -1, 2, -2, 0},
    '{0, 1,  1, 4,  4, 0},
    '{0, 1, -1, 8, -8, 1}
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFORM,
    S_MUL,
    S_OUT_A,
    S_OUT_B,
    S_DONE
  } state_e;

  typedef logic [DEF_DATA_W-1:0]        data_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

  typedef data_t [0:K-1][0:K-1]               data3x3_t;
  typedef data_t [0:TILE_IN-1][0:TILE_IN-1]   data6x6_t;
  typedef data_t [0:TILE_OUT-1][0:TILE_IN-1]  data4x6_t;
  typedef data_t [0:TILE_OUT-1][0:TILE_OUT-1] data4x4_t;

  typedef acc_t [0:K-1][0:K-1]                acc3x3_t;
  typedef acc_t [0:TILE_IN-1][0:TILE_IN-1]    acc6x6_t;
  typedef acc_t [0:TILE_OUT-1][0:TILE_IN-1]   acc4x6_t;
  typedef acc_t [0:TILE_OUT-1][0:TILE_OUT-1]  acc4x4_t;

endpackage

// File: rtl/winograd_output_xform.sv
// Combinational Winograd output transform, split in two halves so the
// caller can put a register between them.
//   m_in  : 6x6 element-wise product M (ACC_W, signed)
//   t_out : A^T * M (4x6, ACC_W)
//   t_in  : registered A^T * M (4x6, ACC_W)
//   y_out : (t_in * A) / 576, truncated to DATA_W (4x4)
module winograd_output_xform
  import winograd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [0:TILE_IN-1][0:TILE_IN-1][ACC_W-1:0]    m_in,
  input  logic [0:TILE_OUT-1][0:TILE_IN-1][ACC_W-1:0]   t_in,
  output logic [0:TILE_OUT-1][0:TILE_IN-1][ACC_W-1:0]   t_out,
  output logic [0:TILE_OUT-1][0:TILE_OUT-1][DATA_W-1:0] y_out
);

  typedef logic signed [ACC_W-1:0] sacc_t;

  always_comb begin : left_mul
    sacc_t sum;
    sum   = '0;
    t_out = '0;
    for (int unsigned i = 0; i < TILE_OUT; i++) begin
      for (int unsigned j = 0; j < TILE_IN; j++) begin
        sum = '0;
        for (int unsigned k = 0; k < TILE_IN; k++) begin
          sum = sum + sacc_t'(AT[i][k]) * sacc_t'(m_in[k][j]);
        end
        t_out[i][j] = sum;
      end
    end
  end

  always_comb begin : right_mul_scale
    sacc_t sum;
    sacc_t quo;
    sum   = '0;
    quo   = '0;
    y_out = '0;
    for (int unsigned i = 0; i < TILE_OUT; i++) begin
      for (int unsigned j = 0; j < TILE_OUT; j++) begin
        sum = '0;
        for (int unsigned k = 0; k < TILE_IN; k++) begin
          sum = sum + sacc_t'(t_in[i][k]) * sacc_t'(AT[j][k]);
        end
        // Both sides carry the 24x kernel scale, so this division is exact.
        quo         = sum / sacc_t'(SCALE);
        y_out[i][j] = quo[DATA_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tile_controller.sv
// Winograd F(4x4,3x3) tile engine: a 3x3 kernel and a 6x6 input tile give
// the 4x4 valid correlation of the tile with the (unflipped) kernel.
//   clk        : clock, rising edge
//   rst_n      : synchronous reset, active-high
//   start      : one-cycle request; kernel_in/tile_in latched on that edge
//   kernel_in  : 3x3 kernel g[u][v]
//   tile_in    : 6x6 tile d[r][c]
//   result_out : 4x4 result Y[i][j], registered, held until next write
//   done       : one-cycle pulse while result_out is freshly valid
// Pipeline: IDLE -> XFORM (U', V) -> MUL (M) -> OUT_A (T) -> OUT_B (Y) -> DONE.
module tile_controller
  import winograd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic [0:K-1][0:K-1][DATA_W-1:0]               kernel_in,
  input  logic [0:TILE_IN-1][0:TILE_IN-1][DATA_W-1:0]   tile_in,
  output logic [0:TILE_OUT-1][0:TILE_OUT-1][DATA_W-1:0] result_out,
  output logic                                          done
);

  typedef logic signed [ACC_W-1:0] sacc_t;

  state_e state_q, state_d;

  logic [0:K-1][0:K-1][ACC_W-1:0]               g_q, g_d;
  logic [0:TILE_IN-1][0:TILE_IN-1][ACC_W-1:0]   d_q, d_d;
  logic [0:TILE_IN-1][0:TILE_IN-1][ACC_W-1:0]   u_q, u_d;
  logic [0:TILE_IN-1][0:TILE_IN-1][ACC_W-1:0]   v_q, v_d;
  logic [0:TILE_IN-1][0:TILE_IN-1][ACC_W-1:0]   m_q, m_d;
  logic [0:TILE_OUT-1][0:TILE_IN-1][ACC_W-1:0]  t_q, t_d;
  logic [0:TILE_OUT-1][0:TILE_OUT-1][DATA_W-1:0] res_q, res_d;
  logic                                          done_q, done_d;

  logic [0:TILE_IN-1][0:K-1][ACC_W-1:0]          gk_w;
  logic [0:TILE_IN-1][0:TILE_IN-1][ACC_W-1:0]    u_w;
  logic [0:TILE_IN-1][0:TILE_IN-1][ACC_W-1:0]    bd_w;
  logic [0:TILE_IN-1][0:TILE_IN-1][ACC_W-1:0]    v_w;
  logic [0:TILE_OUT-1][0:TILE_IN-1][ACC_W-1:0]   t_w;
  logic [0:TILE_OUT-1][0:TILE_OUT-1][DATA_W-1:0] y_w;

  // Kernel transform U' = G' g G'^T
  always_comb begin : kernel_xform
    sacc_t sum;
    sum  = '0;
    gk_w = '0;
    u_w  = '0;
    for (int unsigned i = 0; i < TILE_IN; i++) begin
      for (int unsigned j = 0; j < K; j++) begin
        sum = '0;
        for (int unsigned k = 0; k < K; k++) begin
          sum = sum + sacc_t'(GS[i][k]) * sacc_t'(g_q[k][j]);
        end
        gk_w[i][j] = sum;
      end
    end
    for (int unsigned i = 0; i < TILE_IN; i++) begin
      for (int unsigned j = 0; j < TILE_IN; j++) begin
        sum = '0;
        for (int unsigned k = 0; k < K; k++) begin
          sum = sum + sacc_t'(gk_w[i][k]) * sacc_t'(GS[j][k]);
        end
        u_w[i][j] = sum;
      end
    end
  end

  // Input transform V = B^T d B
  always_comb begin : input_xform
    sacc_t sum;
    sum  = '0;
    bd_w = '0;
    v_w  = '0;
    for (int unsigned i = 0; i < TILE_IN; i++) begin
      for (int unsigned j = 0; j < TILE_IN; j++) begin
        sum = '0;
        for (int unsigned k = 0; k < TILE_IN; k++) begin
          sum = sum + sacc_t'(BT[i][k]) * sacc_t'(d_q[k][j]);
        end
        bd_w[i][j] = sum;
      end
    end
    for (int unsigned i = 0; i < TILE_IN; i++) begin
      for (int unsigned j = 0; j < TILE_IN; j++) begin
        sum = '0;
        for (int unsigned k = 0; k < TILE_IN; k++) begin
          sum = sum + sacc_t'(bd_w[i][k]) * sacc_t'(BT[j][k]);
        end
        v_w[i][j] = sum;
      end
    end
  end

  winograd_output_xform #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_out_xform (
    .m_in (m_q),
    .t_in (t_q),
    .t_out(t_w),
    .y_out(y_w)
  );

  always_comb begin : fsm_next
    state_d = state_q;
    g_d     = g_q;
    d_d     = d_q;
    u_d     = u_q;
    v_d     = v_q;
    m_d     = m_q;
    t_d     = t_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
              g_d[r][c] = sacc_t'($signed(kernel_in[r][c]));
            end
          end
          for (int unsigned r = 0; r < TILE_IN; r++) begin
            for (int unsigned c = 0; c < TILE_IN; c++) begin
              d_d[r][c] = sacc_t'($signed(tile_in[r][c]));
            end
          end
          state_d = S_XFORM;
        end
      end
      S_XFORM: begin
        u_d     = u_w;
        v_d     = v_w;
        state_d = S_MUL;
      end
      S_MUL: begin
        for (int unsigned r = 0; r < TILE_IN; r++) begin
          for (int unsigned c = 0; c < TILE_IN; c++) begin
            m_d[r][c] = sacc_t'(u_q[r][c]) * sacc_t'(v_q[r][c]);
          end
        end
        state_d = S_OUT_A;
      end
      S_OUT_A: begin
        t_d     = t_w;
        state_d = S_OUT_B;
      end
      S_OUT_B: begin
        res_d   = y_w;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      d_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      m_q     <= '0;
      t_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      d_q     <= d_d;
      u_q     <= u_d;
      v_q     <= v_d;
      m_q     <= m_d;
      t_q     <= t_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign result_out = res_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tile_controller.sv
module tb_tile_controller;
  import winograd_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     start;
  data3x3_t kernel_in;
  data6x6_t tile_in;
  data4x4_t result_out;
  logic     done;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;
  int n_jobs = 0;
  logic done_prev = 1'b0;
  data4x4_t exp_q[$];

  data4x4_t e1, e2, e3, e4;

  always #5 clk = ~clk;

  tile_controller #(
    .DATA_W(DEF_DATA_W),
    .ACC_W (DEF_ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .kernel_in (kernel_in),
    .tile_in   (tile_in),
    .result_out(result_out),
    .done      (done)
  );

  function automatic void check(input string name, input logic [511:0] act,
                                input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic data4x4_t pack4(input int a [4][4]);
    data4x4_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[i][j] = a[i][j];
    return r;
  endfunction

  function automatic data4x4_t fill4(input int v);
    data4x4_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[i][j] = v;
    return r;
  endfunction

  // mode 0: centre tap only, 1: rows 1..9, else constant val
  function automatic data3x3_t mk_kernel(input int mode, input int val);
    data3x3_t k;
    for (int u = 0; u < 3; u++)
      for (int v = 0; v < 3; v++)
        case (mode)
          0:       k[u][v] = (u == 1 && v == 1) ? 1 : 0;
          1:       k[u][v] = 3 * u + v + 1;
          default: k[u][v] = val;
        endcase
    return k;
  endfunction

  // mode 0: 6r+c+1, 1: (r+c)%10+1, else constant val
  function automatic data6x6_t mk_tile(input int mode, input int val);
    data6x6_t t;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        case (mode)
          0:       t[r][c] = 6 * r + c + 1;
          1:       t[r][c] = (r + c) % 10 + 1;
          default: t[r][c] = val;
        endcase
    return t;
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!rst_n && done) begin
      n_done++;
      check("done_single_cycle", done_prev, 1'b0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with result %0h, expected no done",
                 result_out);
      end else begin
        check("result", result_out, exp_q.pop_front());
      end
    end
    done_prev = rst_n ? 1'b0 : done;
  end

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_job(input data3x3_t k, input data6x6_t t, input data4x4_t e);
    int cyc;
    @(negedge clk);
    kernel_in = k;
    tile_in   = t;
    start     = 1'b1;
    exp_q.push_back(e);
    n_jobs++;
    @(negedge clk);
    start     = 1'b0;
    kernel_in = '1;
    tile_in   = '1;
    wait_done(cyc);
    check("latency", cyc, 5);
    @(negedge clk);
    check("done_width", done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int t1 [4][4] = '{'{8, 9, 10, 11}, '{14, 15, 16, 17},
                      '{20, 21, 22, 23}, '{26, 27, 28, 29}};
    int t3 [4][4] = '{'{159, 204, 249, 294}, '{204, 249, 294, 339},
                      '{249, 294, 339, 384}, '{294, 339, 384, 339}};
    e1 = pack4(t1);
    e2 = fill4(9);
    e3 = pack4(t3);
    e4 = fill4(-18);

    rst_n     = 1'b1;
    start     = 1'b0;
    kernel_in = '1;
    tile_in   = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", result_out, '0);
    check("reset_done", done, 1'b0);
    rst_n = 1'b0;

    run_job(mk_kernel(0, 0), mk_tile(0, 0), e1);
    run_job(mk_kernel(2, 1), mk_tile(2, 1), e2);
    run_job(mk_kernel(1, 0), mk_tile(1, 0), e3);
    run_job(mk_kernel(2, -1), mk_tile(2, 2), e4);

    // Restart attempts mid-job and in DONE, input change after start.
    @(negedge clk);
    kernel_in = mk_kernel(1, 0);
    tile_in   = mk_tile(1, 0);
    start     = 1'b1;
    exp_q.push_back(e3);
    n_jobs++;
    @(negedge clk);                 // XFORM
    start   = 1'b0;
    tile_in = mk_tile(2, 7);
    @(negedge clk);                 // MUL
    kernel_in = mk_kernel(2, 1);
    tile_in   = mk_tile(2, 1);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency_restart", cyc, 5);
    kernel_in = mk_kernel(2, -1);   // start presented in DONE cycle
    tile_in   = mk_tile(2, 2);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("hold_result", result_out, e3);
      @(negedge clk);
    end

    // Reset during OUT_A abandons the job.
    kernel_in = mk_kernel(2, 1);
    tile_in   = mk_tile(2, 1);
    start     = 1'b1;
    @(negedge clk);                 // XFORM
    start = 1'b0;
    @(negedge clk);                 // MUL
    @(negedge clk);                 // OUT_A
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_result", result_out, '0);
    check("midreset_done", done, 1'b0);
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset_no_done", done, 1'b0);
    end

    run_job(mk_kernel(2, 1), mk_tile(2, 1), e2);

    repeat (8) @(negedge clk);
    check("done_count", n_done, n_jobs);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
